// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the two-way data-cache controller.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RMISS = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Byte-address field positions (the offset inside a word is ignored)
    localparam int WORD_SEL_BIT = 2;
    localparam int INDEX_LSB    = 3;

    localparam int LINE_W = 64;
    localparam int WORD_W = 32;

endpackage

// File: rtl/cache_2way_array.sv
// Two-way tag/data storage with one LRU bit per set.
// Lookup is combinational. Fill, word-write and LRU update are synchronous.
module cache_2way_array
    import cache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INDEX_W-1:0]   index,
    input  logic [TAG_W-1:0]     tag,
    output logic                 hit,
    output logic                 hit_way,
    output logic [LINE_W-1:0]    line,
    output logic                 victim_way,
    input  logic                 fill_en,
    input  logic                 fill_way,
    input  logic [LINE_W-1:0]    fill_line,
    input  logic                 word_wr_en,
    input  logic                 word_wr_way,
    input  logic                 word_sel,
    input  logic [WORD_W-1:0]    word_wr_data,
    input  logic                 lru_en,
    input  logic                 lru_way
);
    localparam int SETS = 2 ** INDEX_W;

    logic [1:0]        match;
    logic [1:0]        valid_sel;
    logic [LINE_W-1:0] line_w [2];
    logic [SETS-1:0]   lru_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_way
            logic [SETS-1:0]   valid_reg;
            logic [TAG_W-1:0]  tag_reg  [SETS];
            logic [LINE_W-1:0] data_reg [SETS];

            assign valid_sel[gi] = valid_reg[index];
            assign match[gi]     = valid_reg[index] && (tag_reg[index] == tag);
            assign line_w[gi]    = data_reg[index];

            // Valid bits: cleared on reset, set when this way is filled
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= '0;
                end else if (fill_en && (fill_way == gi[0])) begin
                    valid_reg[index] <= 1'b1;
                end
            end

            // Tag and line storage: no reset, the valid bit qualifies them
            always_ff @(posedge clk) begin
                if (fill_en && (fill_way == gi[0])) begin
                    tag_reg[index]  <= tag;
                    data_reg[index] <= fill_line;
                end else if (word_wr_en && (word_wr_way == gi[0])) begin
                    if (word_sel) begin
                        data_reg[index][LINE_W-1:WORD_W] <= word_wr_data;
                    end else begin
                        data_reg[index][WORD_W-1:0] <= word_wr_data;
                    end
                end
            end
        end
    endgenerate

    // LRU points at the way not touched most recently
    always_ff @(posedge clk) begin
        if (rst) begin
            lru_reg <= '0;
        end else if (lru_en) begin
            lru_reg[index] <= ~lru_way;
        end
    end

    assign hit        = |match;
    assign hit_way    = match[1];
    assign line       = line_w[hit_way];
    // An empty way is always preferred, way 0 first
    assign victim_way = ~valid_sel[0] ? 1'b0 :
                        (~valid_sel[1] ? 1'b1 : lru_reg[index]);

endmodule

// File: rtl/cache_controller_2way.sv
// Write-through, no-write-allocate two-way data-cache controller between
// the MEM stage and the SRAM controller, with saturating hit/miss counters.
module cache_controller_2way
    import cache_ctrl_pkg::*;
#(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 10,
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    input  logic               MEM_R_EN,
    input  logic               MEM_W_EN,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [31:0]        sram_address,
    output logic [31:0]        sram_wdata,
    output logic               write,
    output logic               read,
    input  logic [63:0]        sram_rdata,
    input  logic               sram_ready,
    output logic [COUNT_W-1:0] hit_count,
    output logic [COUNT_W-1:0] miss_count
);
    localparam int TAG_LSB = INDEX_LSB + INDEX_W;

    state_t state_reg, state_next;

    logic [INDEX_W-1:0] index;
    logic [TAG_W-1:0]   tag;
    logic               word_sel;
    logic               hit, hit_way, victim_way;
    logic [LINE_W-1:0]  line;
    logic [WORD_W-1:0]  hit_word, fill_word;
    logic               fill_en, word_wr_en, lru_en, lru_way;
    logic               hit_inc, miss_inc;
    logic [COUNT_W-1:0] hit_count_reg, miss_count_reg;
    logic               unused_addr_bits;

    assign word_sel  = address[WORD_SEL_BIT];
    assign index     = address[INDEX_LSB +: INDEX_W];
    assign tag       = address[TAG_LSB +: TAG_W];
    assign hit_word  = word_sel ? line[LINE_W-1:WORD_W] : line[WORD_W-1:0];
    assign fill_word = word_sel ? sram_rdata[LINE_W-1:WORD_W] : sram_rdata[WORD_W-1:0];
    assign unused_addr_bits = ^{address[31:TAG_LSB+TAG_W], address[1:0]};

    cache_2way_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .index        (index),
        .tag          (tag),
        .hit          (hit),
        .hit_way      (hit_way),
        .line         (line),
        .victim_way   (victim_way),
        .fill_en      (fill_en),
        .fill_way     (victim_way),
        .fill_line    (sram_rdata),
        .word_wr_en   (word_wr_en),
        .word_wr_way  (hit_way),
        .word_sel     (word_sel),
        .word_wr_data (wdata),
        .lru_en       (lru_en),
        .lru_way      (lru_way)
    );

    // Next state, handshake outputs and array update strobes; reset masks all
    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        rdata      = '0;
        fill_en    = 1'b0;
        word_wr_en = 1'b0;
        lru_en     = 1'b0;
        lru_way    = hit_way;
        hit_inc    = 1'b0;
        miss_inc   = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (MEM_W_EN) begin
                        state_next = WRITE;
                    end else if (MEM_R_EN) begin
                        if (hit) begin
                            ready   = 1'b1;
                            rdata   = hit_word;
                            lru_en  = 1'b1;
                            hit_inc = 1'b1;
                        end else begin
                            state_next = RMISS;
                            miss_inc   = 1'b1;
                        end
                    end
                end
                RMISS: begin
                    read = 1'b1;
                    if (sram_ready) begin
                        fill_en    = 1'b1;
                        lru_en     = 1'b1;
                        lru_way    = victim_way;
                        ready      = 1'b1;
                        rdata      = fill_word;
                        state_next = IDLE;
                    end
                end
                WRITE: begin
                    write = 1'b1;
                    if (sram_ready) begin
                        ready      = 1'b1;
                        state_next = IDLE;
                        if (hit) begin
                            word_wr_en = 1'b1;
                            lru_en     = 1'b1;
                        end
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (hit_inc && (hit_count_reg != '1)) begin
                hit_count_reg <= hit_count_reg + 1'b1;
            end
            if (miss_inc && (miss_count_reg != '1)) begin
                miss_count_reg <= miss_count_reg + 1'b1;
            end
        end
    end

    assign sram_address = address;
    assign sram_wdata   = wdata;
    assign hit_count    = hit_count_reg;
    assign miss_count   = miss_count_reg;

endmodule

// File: tb/tb_cache_controller_2way.sv
// Randomized self-checking bench: a set-associative cache model with LRU plus
// a backing memory predicts every cycle of the controller's behaviour.
module tb_cache_controller_2way;
    localparam int INDEX_W = 6;
    localparam int TAG_W   = 10;
    localparam int COUNT_W = 5;
    localparam int SETS    = 1 << INDEX_W;
    localparam int CMAX    = (1 << COUNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [31:0]        address = '0;
    logic [31:0]        wdata = '0;
    logic               MEM_R_EN = 1'b0;
    logic               MEM_W_EN = 1'b0;
    logic [31:0]        rdata;
    logic               ready;
    logic [31:0]        sram_address;
    logic [31:0]        sram_wdata;
    logic               write;
    logic               read;
    logic [63:0]        sram_rdata = '0;
    logic               sram_ready = 1'b0;
    logic [COUNT_W-1:0] hit_count;
    logic [COUNT_W-1:0] miss_count;

    cache_controller_2way #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .COUNT_W (COUNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address      (address),
        .wdata        (wdata),
        .MEM_R_EN     (MEM_R_EN),
        .MEM_W_EN     (MEM_W_EN),
        .rdata        (rdata),
        .ready        (ready),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .write        (write),
        .read         (read),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: residency per set/way, LRU victim per set, memory image
    bit               mv   [SETS][2];
    bit [TAG_W-1:0]   mt   [SETS][2];
    bit               mlru [SETS];
    logic [63:0]      mem  [int unsigned];
    int               m_hits = 0;
    int               m_misses = 0;

    // Expected outputs for the current cycle
    logic        exp_ready = 0, exp_read = 0, exp_write = 0, exp_rd_chk = 0;
    logic [31:0] exp_rdata = '0;
    bit          chk_en = 0;

    int n_checks = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, expv, $time);
    endtask

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 3) % SETS);
    endfunction

    function automatic logic [TAG_W-1:0] tag_of(input logic [31:0] a);
        return TAG_W'(a >> (3 + INDEX_W));
    endfunction

    function automatic logic [63:0] get_line(input logic [31:0] a);
        int unsigned k;
        k = a >> 3;
        if (!mem.exists(k)) mem[k] = {$urandom, $urandom};
        return mem[k];
    endfunction

    function automatic logic [31:0] word_of(input logic [63:0] ln, input logic [31:0] a);
        return a[2] ? ln[63:32] : ln[31:0];
    endfunction

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic lookup(input logic [31:0] a, output bit h, output bit w);
        int s;
        s = set_of(a);
        h = 0;
        w = 0;
        for (int i = 0; i < 2; i++) begin
            if (mv[s][i] && mt[s][i] == tag_of(a)) begin
                h = 1;
                w = i[0];
            end
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            mv[s][0] = 0;
            mv[s][1] = 0;
            mlru[s] = 0;
        end
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic set_exp(input logic r, input logic rd, input logic wr,
                           input logic rc, input logic [31:0] d);
        exp_ready  = r;
        exp_read   = rd;
        exp_write  = wr;
        exp_rd_chk = rc;
        exp_rdata  = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of DUT outputs against the model's expectation
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 64'(ready), 64'(exp_ready));
            chk("read", 64'(read), 64'(exp_read));
            chk("write", 64'(write), 64'(exp_write));
            chk("hit_count", 64'(hit_count), 64'(m_hits));
            chk("miss_count", 64'(miss_count), 64'(m_misses));
            if (exp_rd_chk) chk("rdata", 64'(rdata), 64'(exp_rdata));
            if (exp_read || exp_write) chk("sram_address", 64'(sram_address), 64'(address));
            if (exp_write) chk("sram_wdata", 64'(sram_wdata), 64'(wdata));
        end
    end

    task automatic idle_cycle(input logic [31:0] a);
        bit h, w;
        MEM_R_EN = 0;
        MEM_W_EN = 0;
        address = a;
        sram_ready = 1'($urandom % 2);
        lookup(a, h, w);
        set_exp(0, 0, 0, !h, '0);
        step();
        sram_ready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int lat,
                           output bit obs_hit, output logic [31:0] obs_rdata);
        bit h, w, v, last;
        int s;
        logic [63:0] ln;
        lookup(a, h, w);
        s = set_of(a);
        ln = get_line(a);
        address = a;
        MEM_R_EN = 1;
        MEM_W_EN = 0;
        sram_ready = 0;
        sram_rdata = {$urandom, $urandom};
        obs_rdata = '0;
        if (h) begin
            set_exp(1, 0, 0, 1, word_of(ln, a));
            #2;
            obs_hit = ready;
            obs_rdata = rdata;
            step();
            mlru[s] = ~w;
            m_hits = sat(m_hits);
        end else begin
            set_exp(0, 0, 0, 0, '0);
            #2;
            obs_hit = ready;
            step();
            m_misses = sat(m_misses);
            for (int i = 0; i < lat; i++) begin
                last = (i == lat - 1);
                sram_ready = last;
                sram_rdata = last ? ln : {$urandom, $urandom};
                set_exp(last, 1, 0, last, word_of(ln, a));
                if (last) begin
                    #2;
                    obs_rdata = rdata;
                end
                step();
            end
            v = !mv[s][0] ? 1'b0 : (!mv[s][1] ? 1'b1 : mlru[s]);
            mv[s][v] = 1;
            mt[s][v] = tag_of(a);
            mlru[s] = ~v;
        end
        MEM_R_EN = 0;
        sram_ready = 0;
        set_exp(0, 0, 0, 0, '0);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input bit both, input int lat);
        bit h, w, last;
        int s;
        logic [63:0] ln;
        lookup(a, h, w);
        s = set_of(a);
        address = a;
        wdata = d;
        MEM_W_EN = 1;
        MEM_R_EN = both;
        sram_ready = 0;
        set_exp(0, 0, 0, 0, '0);
        step();
        for (int i = 0; i < lat; i++) begin
            last = (i == lat - 1);
            sram_ready = last;
            set_exp(last, 0, 1, 0, '0);
            step();
        end
        ln = get_line(a);
        if (a[2]) ln[63:32] = d;
        else ln[31:0] = d;
        mem[a >> 3] = ln;
        if (h) mlru[s] = ~w;
        MEM_W_EN = 0;
        MEM_R_EN = 0;
        sram_ready = 0;
        set_exp(0, 0, 0, 0, '0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ({$urandom} % 4) << (3 + INDEX_W);
        a = a | (({$urandom} % 4) << 3) | ({$urandom} % 8);
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        bit          h;
        logic [31:0] r;
        int          op;

        model_reset();
        rst = 1;
        set_exp(0, 0, 0, 1, '0);
        step();
        chk_en = 1;
        step();
        rst = 0;
        idle_cycle(32'h0);

        // Cold read, fill after 3 cycles, then zero-latency reread
        mem[32'h104 >> 3] = 64'hAAAA_BBBB_CCCC_DDDD;
        do_read(32'h0000_0104, 3, h, r);
        chk("cold_miss", 64'(h), 64'd0);
        chk("cold_fill_rdata", 64'(r), 64'hAAAA_BBBB);
        do_read(32'h0000_0104, 3, h, r);
        chk("reread_hit", 64'(h), 64'd1);
        chk("reread_rdata", 64'(r), 64'hAAAA_BBBB);
        #2;
        chk("hit_count_1", 64'(hit_count), 64'd1);
        chk("miss_count_1", 64'(miss_count), 64'd1);

        // Two ways in one set, then LRU eviction
        do_read(32'h0000_0008, 2, h, r);
        do_read(32'h0000_0208, 1, h, r);
        do_read(32'h0000_0008, 1, h, r);
        chk("way0_hit", 64'(h), 64'd1);
        do_read(32'h0000_0208, 1, h, r);
        chk("way1_hit", 64'(h), 64'd1);
        do_read(32'h0000_0408, 2, h, r);
        chk("third_tag_miss", 64'(h), 64'd0);
        do_read(32'h0000_0208, 1, h, r);
        chk("mru_kept", 64'(h), 64'd1);
        do_read(32'h0000_0008, 1, h, r);
        chk("lru_evicted", 64'(h), 64'd0);

        // Write-through hit updates the line; write miss does not allocate
        do_write(32'h0000_0104, 32'hDEAD_BEEF, 0, 3);
        do_read(32'h0000_0104, 1, h, r);
        chk("write_hit_then_hit", 64'(h), 64'd1);
        chk("write_hit_rdata", 64'(r), 64'hDEAD_BEEF);
        do_write(32'h0000_0300, 32'h1234_5678, 0, 2);
        do_read(32'h0000_0300, 2, h, r);
        chk("no_write_alloc", 64'(h), 64'd0);
        chk("no_write_alloc_rdata", 64'(r), 64'h1234_5678);

        // Simultaneous read and write: write wins, no miss counted
        do_write(32'h0000_0010, 32'h0BAD_F00D, 1, 2);
        idle_cycle(32'h0000_0010);
        #2;
        chk("both_en_miss_count", 64'(miss_count), 64'd6);
        chk("both_en_hit_count", 64'(hit_count), 64'd5);

        // Reset during a read miss with sram_ready in the same cycle
        address = 32'h0000_0500;
        MEM_R_EN = 1;
        set_exp(0, 0, 0, 0, '0);
        step();
        m_misses = sat(m_misses);
        set_exp(0, 1, 0, 0, '0);
        step();
        rst = 1;
        sram_ready = 1;
        sram_rdata = get_line(32'h0000_0500);
        set_exp(0, 0, 0, 1, '0);
        step();
        rst = 0;
        sram_ready = 0;
        MEM_R_EN = 0;
        model_reset();
        set_exp(0, 0, 0, 1, '0);
        #2;
        chk("rst_hit_count", 64'(hit_count), 64'd0);
        chk("rst_miss_count", 64'(miss_count), 64'd0);
        step();
        do_read(32'h0000_0500, 2, h, r);
        chk("rst_no_fill", 64'(h), 64'd0);
        do_read(32'h0000_0104, 1, h, r);
        chk("rst_invalidated", 64'(h), 64'd0);

        // LRU thrash on one set to saturate the miss counter
        for (int i = 0; i < 40; i++) begin
            do_read(32'((4 + i % 3) << (3 + INDEX_W)) | 32'(10 << 3), 1 + i % 3, h, r);
        end
        idle_cycle(32'h0);
        #2;
        chk("miss_saturated", 64'(miss_count), 64'h1F);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            op = $urandom % 10;
            if (op < 4) do_read(rand_addr(), 1 + $urandom % 4, h, r);
            else if (op < 7) do_write(rand_addr(), $urandom, 0, 1 + $urandom % 4);
            else if (op < 8) do_write(rand_addr(), $urandom, 1, 1 + $urandom % 4);
            else idle_cycle(rand_addr());
        end
        idle_cycle(32'h0);
        #2;
        chk("final_miss_count", 64'(miss_count), 64'h1F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
